fifo_serial_reader: RTL
=======================

Name: fifo_serial_reader

Overview:
- Read-side companion for the team's parallel FIFO register: drains words through the FIFO's data-out-ready / read-enable handshake and re-emits each word as a serial bit stream with a valid/ready handshake.
- Adds an optional even-parity bit per word and keeps a wrap-around count of words sent.
- Sits between the FIFO output stage and any bit-serial consumer (link driver, shift chain).

Parameters:
- WIDTH, 4, data word width in bits; must match the FIFO width; minimum 2.
- PARITY, 0, 1 = append an even-parity bit after the data bits of each word; 0 = data bits only.
- CNT_W, 8, width of the word_count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; clears all state.
- en  input  1  fetch enable; 0 blocks new FIFO reads but lets the current word complete.
- fifo_dor  input  1  FIFO data-out-ready level; 1 = at least one valid word available.
- fifo_data  input  WIDTH  FIFO parallel output; valid the cycle after a fifo_r_en pulse.
- fifo_r_en  output  1  registered one-cycle read strobe to the FIFO.
- ser_ready  input  1  downstream accepts the current bit this cycle.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_out  output  1  current serial bit, LSB first.
- ser_last  output  1  high with the final bit of a frame (parity bit if PARITY=1, else data MSB).
- busy  output  1  high in any state other than IDLE.
- word_count  output  CNT_W  number of frames fully accepted downstream, modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): state=IDLE; fifo_r_en=0; ser_valid=0; ser_out=0; ser_last=0; busy=0; word_count=0; shift register and bit counter cleared. Reset mid-frame abandons the frame and does not increment word_count.
- FSM states and transitions:
  - IDLE: if en && fifo_dor, next = READ.
  - READ: fifo_r_en=1 for exactly this cycle; next = CAPTURE.
  - CAPTURE: latch fifo_data into the shift register; compute parity = XOR of the data bits; clear the bit counter; next = SHIFT.
  - SHIFT: ser_valid=1 and ser_out = current bit. A bit advances only on a cycle with ser_valid && ser_ready; ser_out is held stable while ser_ready=0.
- Frame length: WIDTH+PARITY bits. The parity bit (PARITY=1) follows data bit WIDTH-1. ser_last is asserted together with ser_valid on the final bit.
- Frame acceptance (final bit accepted):
  - word_count increments, wrapping from 2^CNT_W-1 to 0.
  - If en && fifo_dor, next = READ (back-to-back fetch); else next = IDLE.
- Latency: fifo_dor rising in IDLE with en=1 gives fifo_r_en at cycle +1 and first ser_valid at cycle +3. Back-to-back frames leave a 2-cycle gap (READ, CAPTURE) with ser_valid=0.
- en is sampled only in IDLE and at frame acceptance. Deasserting en in READ, CAPTURE or SHIFT does not abort the frame.
- fifo_dor is sampled at the same points as en. A fifo_dor drop after READ does not cancel the capture.
- Exactly one fifo_r_en pulse is issued per frame. The block never reads while fifo_dor=0.
- Sustained ser_ready=0 in SHIFT stalls indefinitely with all outputs held; no timeout.
- busy = (state != IDLE).

Test Plan:
- Single word, WIDTH=4, PARITY=0: fifo_dor=1 for one fetch, fifo_data=4'b1011, ser_ready=1 -> one fifo_r_en pulse at cycle +1; ser_out sequence 1,1,0,1 on cycles +3..+6; ser_last on the 4th bit; word_count=1; busy returns to 0.
- Parity, PARITY=1: data=4'b0111 -> 5 bits 1,1,1,0 then parity 1, with ser_last on the parity bit; then data=4'b0011 -> parity bit 0.
- Backpressure: toggle ser_ready 1,0,0,1,... during SHIFT -> ser_out and ser_valid held through stalls; no bit skipped or duplicated; word_count increments only after the final accepted bit.
- Back-to-back: fifo_dor held high, en=1, three words A,B,C -> three fifo_r_en pulses, each spaced WIDTH+PARITY+2 cycles with ser_ready=1; frames emitted in order; word_count=3.
- en drop mid-frame: deassert en during bit 2 -> frame completes; no further fifo_r_en while fifo_dor=1; FSM stays in IDLE until en=1.
- Reset and wrap: async rst pulse mid-SHIFT -> all outputs 0 immediately, word_count=0. With CNT_W=2, send 5 frames -> word_count reads 1.

Source files
------------

// File: rtl/fifo_serial_reader.sv
// Drains words from the parallel FIFO via dor/r_en and re-emits them LSB-first
// on a valid/ready serial port, with optional even parity and a frame counter.
module fifo_serial_reader #(
  parameter int WIDTH  = 4,
  parameter int PARITY = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_dor,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_en,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int FRAME_LEN = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SHIFT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [FRAME_LEN-1:0] r_shift;
  logic [FRAME_LEN-1:0] w_load;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 r_rd_en;
  logic [CNT_W-1:0]     r_word_count;
  logic                 w_fetch;
  logic                 w_accept;
  logic                 w_frame_done;

  assign w_fetch      = en && fifo_dor;
  assign w_accept     = (r_state == S_SHIFT) && ser_ready;
  assign w_frame_done = w_accept && (r_bit_cnt == LAST_IDX);

  // The parity bit sits just above the data MSB so a plain right shift emits it last.
  generate
    if (PARITY != 0) begin : g_parity
      assign w_load = {^fifo_data, fifo_data};
    end else begin : g_no_parity
      assign w_load = fifo_data;
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_fetch) w_next = S_READ;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_frame_done) w_next = w_fetch ? S_READ : S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobe is registered from the next-state decode, so it is high exactly during READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= (w_next == S_READ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_shift   <= w_load;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= w_frame_done ? '0 : r_bit_cnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_frame_done) begin
      r_word_count <= r_word_count + CNT_W'(1);
    end
  end

  assign fifo_r_en  = r_rd_en;
  assign ser_valid  = (r_state == S_SHIFT);
  assign ser_out    = ser_valid && r_shift[0];
  assign ser_last   = ser_valid && (r_bit_cnt == LAST_IDX);
  assign busy       = (r_state != S_IDLE);
  assign word_count = r_word_count;

endmodule
